// File: rtl/uart_reg_access_pkg.sv
// -----------------------------------------------------------------------------
// uart_reg_access_pkg
// Shared definitions for the UART register-access bridge: the FSM state
// encoding and the default register-file geometry.
// -----------------------------------------------------------------------------
package uart_reg_access_pkg;

    // Default register-file geometry
    localparam int unsigned REG_WIDTH_DEF  = 32;
    localparam int unsigned NUM_REGS_DEF   = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 4;

    // FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ACCESS = ACCESS,
        ST_RESP   = RESP
    } state_e;

endpackage : uart_reg_access_pkg

// File: rtl/uart_reg_access.sv
// -----------------------------------------------------------------------------
// uart_reg_access
// Bridges a single-outstanding command/response stream (typically fed by a
// UART command parser) onto a flat register file. Each accepted command
// produces a one-cycle one-hot write or read strobe, then a held response.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   cmd_valid_i  : command valid
//   cmd_ready_o  : command accepted (high only while idle)
//   cmd_write_i  : 1 = write, 0 = read
//   cmd_addr_i   : register index
//   cmd_wdata_i  : write data
//   rsp_valid_o  : response valid (held until rsp_ready_i)
//   rsp_ready_i  : response consumed
//   rsp_rdata_o  : read data (0 for writes and errors)
//   rsp_err_o    : address was out of range
//   reg_wr_en_o  : one-hot write strobe per register
//   reg_rd_en_o  : one-hot read strobe per register
//   reg_wdata_o  : write data to every register
//   reg_rdata_i  : flattened register outputs, register k at [k*REG_WIDTH +: REG_WIDTH]
// -----------------------------------------------------------------------------
module uart_reg_access
    import uart_reg_access_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = REG_WIDTH_DEF,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
    input  logic [REG_WIDTH-1:0]          cmd_wdata_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [REG_WIDTH-1:0]          rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic [NUM_REGS-1:0]           reg_wr_en_o,
    output logic [NUM_REGS-1:0]           reg_rd_en_o,
    output logic [REG_WIDTH-1:0]          reg_wdata_o,
    input  logic [NUM_REGS*REG_WIDTH-1:0] reg_rdata_i
);

    // Register count widened by one bit so NUM_REGS == 2**ADDR_WIDTH compares correctly
    localparam logic [ADDR_WIDTH:0] NUM_REGS_CMP = (ADDR_WIDTH+1)'(NUM_REGS);

    // True when the address selects an implemented register
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_CMP);
    endfunction

    state_e                  state_r;
    logic                    cmd_ready_r;
    logic                    cmd_write_r;
    logic [ADDR_WIDTH-1:0]   cmd_addr_r;
    logic                    cmd_err_r;
    logic                    rsp_valid_r;
    logic [REG_WIDTH-1:0]    rsp_rdata_r;
    logic                    rsp_err_r;
    logic [NUM_REGS-1:0]     reg_wr_en_r;
    logic [NUM_REGS-1:0]     reg_rd_en_r;
    logic [REG_WIDTH-1:0]    reg_wdata_r;

    logic [NUM_REGS-1:0]     addr_dec_s;
    logic [NUM_REGS-1:0]     rd_sel_s;
    logic [REG_WIDTH-1:0]    reg_word_s [NUM_REGS];
    logic [REG_WIDTH-1:0]    rd_word_s;
    logic                    cmd_in_range_s;

    assign cmd_in_range_s = addr_in_range(cmd_addr_i);

    // Incoming-address decode feeds the strobe registers; the latched-address
    // decode drives the read mux during ACCESS.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_dec
        localparam logic [ADDR_WIDTH-1:0] K_ADDR = ADDR_WIDTH'(k);
        assign addr_dec_s[k] = (cmd_addr_i == K_ADDR);
        assign rd_sel_s[k]   = (cmd_addr_r == K_ADDR);
        assign reg_word_s[k] = reg_rdata_i[k*REG_WIDTH +: REG_WIDTH];
    end

    // AND-OR read mux; an out-of-range address selects nothing and yields 0
    always_comb begin
        rd_word_s = {REG_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel_s[i]) begin
                rd_word_s = rd_word_s | reg_word_s[i];
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Command FSM with all outputs registered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            cmd_write_r <= 1'b0;
            cmd_addr_r  <= {ADDR_WIDTH{1'b0}};
            cmd_err_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {REG_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            reg_wr_en_r <= {NUM_REGS{1'b0}};
            reg_rd_en_r <= {NUM_REGS{1'b0}};
            reg_wdata_r <= {REG_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // cmd_ready_r is set on the first edge after reset release
                    if (cmd_valid_i && cmd_ready_r) begin
                        cmd_write_r <= cmd_write_i;
                        cmd_addr_r  <= cmd_addr_i;
                        cmd_err_r   <= !cmd_in_range_s;
                        reg_wdata_r <= cmd_wdata_i;
                        cmd_ready_r <= 1'b0;
                        // Strobe registered at acceptance so it is live for exactly the ACCESS cycle
                        reg_wr_en_r <= (cmd_write_i && cmd_in_range_s) ? addr_dec_s : {NUM_REGS{1'b0}};
                        reg_rd_en_r <= (!cmd_write_i && cmd_in_range_s) ? addr_dec_s : {NUM_REGS{1'b0}};
                        state_r     <= ST_ACCESS;
                    end else begin
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    reg_wr_en_r <= {NUM_REGS{1'b0}};
                    reg_rd_en_r <= {NUM_REGS{1'b0}};
                    // Capture on the strobe edge: read-clear bits still hold their old value
                    rsp_rdata_r <= (cmd_write_r || cmd_err_r) ? {REG_WIDTH{1'b0}} : rd_word_s;
                    rsp_err_r   <= cmd_err_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= {REG_WIDTH{1'b0}};
                        rsp_err_r   <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= {REG_WIDTH{1'b0}};
                    rsp_err_r   <= 1'b0;
                    reg_wr_en_r <= {NUM_REGS{1'b0}};
                    reg_rd_en_r <= {NUM_REGS{1'b0}};
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign reg_wr_en_o = reg_wr_en_r;
    assign reg_rd_en_o = reg_rd_en_r;
    assign reg_wdata_o = reg_wdata_r;

endmodule : uart_reg_access

// File: tb/tb_uart_reg_access.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_access
// Directed self-checking bench. A small register bank sits behind the DUT;
// register 3 is read-clear (cleared on its read strobe).
// -----------------------------------------------------------------------------
module tb_uart_reg_access;

    localparam int RW = 32;
    localparam int NR = 8;
    localparam int AW = 4;

    logic              clk_i;
    logic              rst_ni;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [AW-1:0]     cmd_addr_i;
    logic [RW-1:0]     cmd_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [RW-1:0]     rsp_rdata_o;
    logic              rsp_err_o;
    logic [NR-1:0]     reg_wr_en_o;
    logic [NR-1:0]     reg_rd_en_o;
    logic [RW-1:0]     reg_wdata_o;
    logic [NR*RW-1:0]  reg_rdata_i;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] bank [NR];

    uart_reg_access #(.REG_WIDTH(RW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .reg_wr_en_o (reg_wr_en_o),
        .reg_rd_en_o (reg_rd_en_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_rdata_i (reg_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Register bank model: writes from strobes, register 3 clears when read
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < NR; k++) bank[k] <= '0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (reg_wr_en_o[k]) bank[k] <= reg_wdata_o;
            end
            if (reg_rd_en_o[3]) bank[3] <= 32'h0;
        end
    end

    // Flatten bank onto the DUT read bus
    always_comb begin
        reg_rdata_i = '0;
        for (int k = 0; k < NR; k++) reg_rdata_i[k*RW +: RW] = bank[k];
    end

    // One full command: drive, sample strobe cycle, sample response, consume it
    task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [RW-1:0] d,
                           output logic rdy_b, output logic [NR-1:0] wr_s, output logic [NR-1:0] rd_s,
                           output logic [RW-1:0] wd_s, output logic [NR-1:0] wr_a, output logic [NR-1:0] rd_a,
                           output logic vld, output logic [RW-1:0] rdat, output logic er,
                           output logic vld_done, output logic rdy_done);
        @(negedge clk_i);
        rdy_b = cmd_ready_o;
        cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_wdata_i = d;
        @(posedge clk_i); #1;
        wr_s = reg_wr_en_o; rd_s = reg_rd_en_o; wd_s = reg_wdata_o;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(posedge clk_i); #1;
        wr_a = reg_wr_en_o; rd_a = reg_rd_en_o;
        vld = rsp_valid_o; rdat = rsp_rdata_o; er = rsp_err_o;
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        vld_done = rsp_valid_o; rdy_done = cmd_ready_o;
        rsp_ready_i = 1'b0;
    endtask

    logic          t_rdy_b, t_vld, t_er, t_vld_done, t_rdy_done;
    logic [NR-1:0] t_wr_s, t_rd_s, t_wr_a, t_rd_a;
    logic [RW-1:0] t_wd_s, t_rdat;

    task automatic test_reset();
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
        cmd_addr_i = '0; cmd_wdata_i = '0; rsp_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata_o); end
        checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err_o); end
        checks++; if ((reg_wr_en_o | reg_rd_en_o) !== 8'h00) begin errors++; $display("FAIL reset_strobes: got %h/%h expected 00/00", reg_wr_en_o, reg_rd_en_o); end
        checks++; if (reg_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", reg_wdata_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL release_ready_before_edge: got %b expected 0", cmd_ready_o); end
        @(posedge clk_i); #1;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready_first_cycle: got %b expected 1", cmd_ready_o); end
    endtask

    task automatic test_write();
        run_cmd(1'b1, 4'd2, 32'hDEADBEEF, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        checks++; if (t_rdy_b !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", t_rdy_b); end
        checks++; if (t_wr_s !== 8'h04) begin errors++; $display("FAIL wr_strobe: got %h expected 04", t_wr_s); end
        checks++; if (t_rd_s !== 8'h00) begin errors++; $display("FAIL wr_no_rd_strobe: got %h expected 00", t_rd_s); end
        checks++; if (t_wd_s !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata: got %h expected deadbeef", t_wd_s); end
        checks++; if (t_wr_a !== 8'h00) begin errors++; $display("FAIL wr_strobe_one_cycle: got %h expected 00", t_wr_a); end
        checks++; if (t_vld !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid: got %b expected 1", t_vld); end
        checks++; if (t_rdat !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata: got %h expected 0", t_rdat); end
        checks++; if (t_er !== 1'b0) begin errors++; $display("FAIL wr_rsp_err: got %b expected 0", t_er); end
        checks++; if (t_vld_done !== 1'b0 || t_rdy_done !== 1'b1) begin errors++; $display("FAIL wr_done: got valid %b ready %b expected 0 1", t_vld_done, t_rdy_done); end
        checks++; if (reg_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata_held: got %h expected deadbeef", reg_wdata_o); end
    endtask

    task automatic test_read();
        run_cmd(1'b1, 4'd5, 32'h0000_00A5, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        run_cmd(1'b0, 4'd5, 32'h0, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        checks++; if (t_rd_s !== 8'h20) begin errors++; $display("FAIL rd_strobe: got %h expected 20", t_rd_s); end
        checks++; if (t_wr_s !== 8'h00) begin errors++; $display("FAIL rd_no_wr_strobe: got %h expected 00", t_wr_s); end
        checks++; if (t_rd_a !== 8'h00) begin errors++; $display("FAIL rd_strobe_one_cycle: got %h expected 00", t_rd_a); end
        checks++; if (t_vld !== 1'b1 || t_rdat !== 32'h0000_00A5) begin errors++; $display("FAIL rd_rsp: got valid %b data %h expected 1 000000a5", t_vld, t_rdat); end
        checks++; if (t_er !== 1'b0) begin errors++; $display("FAIL rd_rsp_err: got %b expected 0", t_er); end
        run_cmd(1'b0, 4'd2, 32'h0, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        checks++; if (t_rdat !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_reg2: got %h expected deadbeef", t_rdat); end
        checks++; if (t_rd_s !== 8'h04) begin errors++; $display("FAIL rd_reg2_strobe: got %h expected 04", t_rd_s); end
    endtask

    task automatic test_read_clear();
        run_cmd(1'b1, 4'd3, 32'h1, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        run_cmd(1'b0, 4'd3, 32'h0, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        checks++; if (t_rdat !== 32'h1) begin errors++; $display("FAIL rc_first_read: got %h expected 1", t_rdat); end
        run_cmd(1'b0, 4'd3, 32'h0, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        checks++; if (t_rdat !== 32'h0) begin errors++; $display("FAIL rc_second_read: got %h expected 0", t_rdat); end
    endtask

    task automatic test_out_of_range();
        run_cmd(1'b0, 4'd9, 32'h0, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        checks++; if ((t_wr_s | t_rd_s) !== 8'h00) begin errors++; $display("FAIL oor_rd_strobe: got %h/%h expected 00/00", t_wr_s, t_rd_s); end
        checks++; if (t_vld !== 1'b1 || t_er !== 1'b1 || t_rdat !== 32'h0) begin errors++; $display("FAIL oor_rd_rsp: got valid %b err %b data %h expected 1 1 0", t_vld, t_er, t_rdat); end
        run_cmd(1'b1, 4'd15, 32'h1234_5678, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        checks++; if ((t_wr_s | t_rd_s) !== 8'h00) begin errors++; $display("FAIL oor_wr_strobe: got %h/%h expected 00/00", t_wr_s, t_rd_s); end
        checks++; if (t_er !== 1'b1 || t_rdat !== 32'h0) begin errors++; $display("FAIL oor_wr_rsp: got err %b data %h expected 1 0", t_er, t_rdat); end
        run_cmd(1'b0, 4'd7, 32'h0, t_rdy_b, t_wr_s, t_rd_s, t_wd_s, t_wr_a, t_rd_a, t_vld, t_rdat, t_er, t_vld_done, t_rdy_done);
        checks++; if (t_er !== 1'b0 || t_rd_s !== 8'h80 || t_rdat !== 32'h0) begin errors++; $display("FAIL top_reg_read: got err %b strobe %h data %h expected 0 80 0", t_er, t_rd_s, t_rdat); end
    endtask

    task automatic test_back_to_back();
        // rsp_ready while idle must not disturb anything
        @(negedge clk_i);
        rsp_ready_i = 1'b1; cmd_valid_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL idle_rsp_ready: got ready %b valid %b expected 1 0", cmd_ready_o, rsp_valid_o); end
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 4'd5; cmd_wdata_i = 32'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_addr_i = 4'd2;
        @(posedge clk_i); #1;
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_00A5) begin errors++; $display("FAIL bp_first_rsp: got valid %b data %h expected 1 000000a5", rsp_valid_o, rsp_rdata_o); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_00A5 || rsp_err_o !== 1'b0 ||
                cmd_ready_o !== 1'b0 || reg_rd_en_o !== 8'h00) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid %b data %h err %b ready %b rd_en %h expected 1 000000a5 0 0 00",
                         i, rsp_valid_o, rsp_rdata_o, rsp_err_o, cmd_ready_o, reg_rd_en_o);
            end
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: got valid %b ready %b expected 0 1", rsp_valid_o, cmd_ready_o); end
        rsp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (reg_rd_en_o !== 8'h04 || cmd_ready_o !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got rd_en %h ready %b expected 04 0", reg_rd_en_o, cmd_ready_o); end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_second_rsp: got valid %b data %h expected 1 deadbeef", rsp_valid_o, rsp_rdata_o); end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_in_access();
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 4'd5; cmd_wdata_i = 32'h0;
        @(posedge clk_i); #1;
        checks++; if (reg_rd_en_o !== 8'h20) begin errors++; $display("FAIL ra_strobe_before: got %h expected 20", reg_rd_en_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (reg_rd_en_o !== 8'h00 || reg_wr_en_o !== 8'h00) begin errors++; $display("FAIL ra_strobe_async_drop: got %h/%h expected 00/00", reg_rd_en_o, reg_wr_en_o); end
        checks++; if (cmd_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || reg_wdata_o !== 32'h0) begin errors++; $display("FAIL ra_outputs_reset: got ready %b valid %b wdata %h expected 0 0 0", cmd_ready_o, rsp_valid_o, reg_wdata_o); end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL ra_after_release: got ready %b valid %b expected 1 0", cmd_ready_o, rsp_valid_o); end
        @(posedge clk_i); #1;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL ra_no_response: got %b expected 0", rsp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_clear();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_reg_access

// File: doc/uart_reg_access.md
UART_REG_ACCESS -- requirements
Module: uart_reg_access

Interface
- REQ-001: The block SHALL have parameter REG_WIDTH, default 32, giving the data width of every register and of the command/response data.
- REQ-002: The block SHALL have parameter NUM_REGS, default 8, giving the number of registers served (1..2**ADDR_WIDTH).
- REQ-003: The block SHALL have parameter ADDR_WIDTH, default 4, giving the command address width.
- REQ-004: The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-005: The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
- REQ-006: The block SHALL have port cmd_valid_i, input, 1 bit: the command is valid.
- REQ-007: The block SHALL have port cmd_ready_o, output, 1 bit: the block accepts a command.
- REQ-008: The block SHALL have port cmd_write_i, input, 1 bit: 1 = write, 0 = read.
- REQ-009: The block SHALL have port cmd_addr_i, input, ADDR_WIDTH bits: register index.
- REQ-010: The block SHALL have port cmd_wdata_i, input, REG_WIDTH bits: write data.
- REQ-011: The block SHALL have port rsp_valid_o, output, 1 bit: the response is valid.
- REQ-012: The block SHALL have port rsp_ready_i, input, 1 bit: the consumer accepts the response.
- REQ-013: The block SHALL have port rsp_rdata_o, output, REG_WIDTH bits: read data; 0 for writes and errors.
- REQ-014: The block SHALL have port rsp_err_o, output, 1 bit: the address was out of range.
- REQ-015: The block SHALL have port reg_wr_en_o, output, NUM_REGS bits: one-hot CPU write strobe per register.
- REQ-016: The block SHALL have port reg_rd_en_o, output, NUM_REGS bits: one-hot CPU read strobe per register.
- REQ-017: The block SHALL have port reg_wdata_o, output, REG_WIDTH bits: data driven to every register's CPU data input.
- REQ-018: The block SHALL have port reg_rdata_i, input, NUM_REGS*REG_WIDTH bits: flattened register outputs, register k at bits [k*REG_WIDTH +: REG_WIDTH].

Function
- REQ-019: The block SHALL implement the FSM states IDLE, ACCESS and RESP, with reset state IDLE.
- REQ-020: The block SHALL drive cmd_ready_o=1 only in IDLE; a handshake (valid&ready) SHALL latch write, addr and wdata and move to ACCESS.
- REQ-021: In ACCESS, for exactly one cycle, the block SHALL assert reg_wr_en_o[addr] (write) or reg_rd_en_o[addr] (read); all other strobe bits SHALL be 0.
- REQ-022: A read SHALL capture reg_rdata_i[addr] in the ACCESS cycle itself, i.e. the pre-clear value, because read-clear bits clear on that edge.
- REQ-023: reg_wdata_o SHALL hold the latched wdata from ACCESS until the next command is accepted.
- REQ-024: An address >= NUM_REGS SHALL assert no strobe; the response SHALL carry rsp_err_o=1 and rsp_rdata_o=0.
- REQ-025: ACCESS SHALL always proceed to RESP after one cycle.
- REQ-026: RESP SHALL hold rsp_valid_o=1 with rsp_rdata_o and rsp_err_o stable until rsp_ready_i=1, then return to IDLE.
- REQ-027: Latency SHALL be: command accepted at edge N, strobe during cycle N+1, rsp_valid_o=1 from cycle N+2.
- REQ-028: Maximum throughput SHALL be one command per 3 cycles; there SHALL be no outstanding-command pipelining.
- REQ-029: A command presented while not in IDLE SHALL be ignored, not lost; cmd_ready_o=0 back-pressures it.
- REQ-030: rsp_ready_i=1 outside RESP SHALL have no effect.
- REQ-031: Strobe outputs SHALL be registered, with no combinational path from cmd_* to reg_*_en_o.

Reset
- REQ-032: rst_ni low SHALL asynchronously force state to IDLE and set cmd_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, reg_wr_en_o=0, reg_rd_en_o=0 and reg_wdata_o=0.
- REQ-033: cmd_ready_o SHALL rise in the first cycle after deassertion.
- REQ-034: Reset during ACCESS SHALL drop the strobe immediately and discard the pending response.

Structure
- REQ-035: The shared package SHALL hold the FSM state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the default REG_WIDTH/NUM_REGS/ADDR_WIDTH constants.
- REQ-036: The block SHALL be a single module with no sub-module; the one-hot address decode and the read mux SHALL be inline generate logic.

Verification
- REQ-037: Write addr 2, data 0xDEADBEEF -> reg_wr_en_o=0x04 for exactly one cycle, reg_wdata_o=0xDEADBEEF, response rdata 0, err 0.
- REQ-038: Read addr 5 with reg_rdata_i[5]=0x0000_00A5 -> reg_rd_en_o=0x20 for one cycle, rsp_rdata_o=0xA5 two cycles after acceptance.
- REQ-039: Read of a read-clear register holding 0x1, which clears on that edge -> response returns 0x1.
- REQ-040: Access addr 9 with NUM_REGS=8 -> no strobe bit set, rsp_err_o=1, rsp_rdata_o=0.
- REQ-041: rsp_ready_i held low 5 cycles with cmd_valid_i=1 -> rsp stable, cmd_ready_o=0 throughout; next command accepted the cycle after rsp_ready_i=1.
- REQ-042: rst_ni pulsed low during ACCESS -> strobes drop to 0 asynchronously, no rsp_valid_o, cmd_ready_o=1 the cycle after release.
